// File: rtl/grf_write_queue.sv
// Write-back queue merging two GRF write producers (A has priority) into one registered GRF write port.
// Latency: accept at edge t, pop into the output register at t+1, GRF commits at t+2; lookup is combinational.
// Backpressure: ready drops when the queue holds DEPTH entries; B is also held off whenever A is presenting.
module grf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic [4:0]    i_a_addr,
  input  logic [31:0]   i_a_data,
  input  logic [31:0]   i_a_pc,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  input  logic [4:0]    i_b_addr,
  input  logic [31:0]   i_b_data,
  input  logic [31:0]   i_b_pc,
  input  logic          i_drain_en,
  output logic          o_grf_we,
  output logic [4:0]    o_grf_a3,
  output logic [31:0]   o_grf_wd,
  output logic [31:0]   o_grf_pc,
  input  logic [4:0]    i_q_addr1,
  input  logic [4:0]    i_q_addr2,
  output logic          o_q_hit1,
  output logic          o_q_hit2,
  output logic [AW:0]   o_count
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_grf_we;
  logic [4:0]      r_grf_a3;
  logic [31:0]     r_grf_wd;
  logic [31:0]     r_grf_pc;

  logic            w_full;
  logic            w_a_fire;
  logic            w_b_fire;
  logic            w_push;
  logic            w_pop;
  entry_t          w_push_ent;
  logic [DEPTH-1:0] w_occ;
  logic            w_hit1;
  logic            w_hit2;

  // Handshake and push/pop decisions; ready looks only at the registered count, so a
  // slot freed by a same-edge pop is not offered to producers until the next cycle.
  always_comb begin
    w_full     = (r_count == (AW+1)'(DEPTH));
    o_a_ready  = ~w_full;
    o_b_ready  = ~w_full & ~i_a_valid;
    w_a_fire   = i_a_valid & o_a_ready;
    w_b_fire   = i_b_valid & o_b_ready;
    // Writes to $0 complete their handshake but are dropped here.
    w_push     = (w_a_fire & (i_a_addr != 5'd0)) | (w_b_fire & (i_b_addr != 5'd0));
    w_push_ent = w_a_fire ? '{addr: i_a_addr, data: i_a_data, pc: i_a_pc}
                          : '{addr: i_b_addr, data: i_b_data, pc: i_b_pc};
    w_pop      = i_drain_en & (r_count != '0);
  end

  // Slot i is occupied when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ[i] = ({1'b0, (AW'(i) - r_rd_ptr)} < r_count);
    end
  end

  // Pending-write lookup over occupied slots plus the in-flight output register.
  always_comb begin
    w_hit1 = r_grf_we & (r_grf_a3 == i_q_addr1);
    w_hit2 = r_grf_we & (r_grf_a3 == i_q_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occ[i] && (r_mem[i].addr == i_q_addr1)) w_hit1 = 1'b1;
      if (w_occ[i] && (r_mem[i].addr == i_q_addr2)) w_hit2 = 1'b1;
    end
    w_hit1 = w_hit1 & (i_q_addr1 != 5'd0);
    w_hit2 = w_hit2 & (i_q_addr2 != 5'd0);
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_ent;
  end

  // Pointers, occupancy and the registered GRF write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_grf_we <= 1'b0;
      r_grf_a3 <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_grf_a3 <= r_mem[r_rd_ptr].addr;
        r_grf_wd <= r_mem[r_rd_ptr].data;
        r_grf_pc <= r_mem[r_rd_ptr].pc;
      end
      r_grf_we <= w_pop;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_grf_we = r_grf_we;
  assign o_grf_a3 = r_grf_a3;
  assign o_grf_wd = r_grf_wd;
  assign o_grf_pc = r_grf_pc;
  assign o_q_hit1 = w_hit1;
  assign o_q_hit2 = w_hit2;
  assign o_count  = r_count;

endmodule

// File: tb/tb_grf_write_queue.sv
// Bench for grf_write_queue: directed scenarios plus random traffic against a queue-based model.
// Inputs change 1 time unit after posedge; outputs are compared on the negedge.
// The model is a plain SystemVerilog queue of accepted writes plus the last popped write.
module tb_grf_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_a_valid, i_b_valid, i_drain_en;
  logic          o_a_ready, o_b_ready;
  logic [4:0]    i_a_addr, i_b_addr, i_q_addr1, i_q_addr2;
  logic [31:0]   i_a_data, i_a_pc, i_b_data, i_b_pc;
  logic          o_grf_we, o_q_hit1, o_q_hit2;
  logic [4:0]    o_grf_a3;
  logic [31:0]   o_grf_wd, o_grf_pc;
  logic [AW:0]   o_count;

  grf_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_pc(i_a_pc),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_pc(i_b_pc),
    .i_drain_en(i_drain_en),
    .o_grf_we(o_grf_we), .o_grf_a3(o_grf_a3), .o_grf_wd(o_grf_wd), .o_grf_pc(o_grf_pc),
    .i_q_addr1(i_q_addr1), .i_q_addr2(i_q_addr2),
    .o_q_hit1(o_q_hit1), .o_q_hit2(o_q_hit2),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Values sampled at the last negedge, for directed checks of combinational outputs.
  logic s_a_ready, s_b_ready, s_hit1, s_hit2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [4:0] addr);
    bit h = 1'b0;
    if (addr == 5'd0) return 1'b0;
    if (m_we && m_a3 == addr) h = 1'b1;
    foreach (mq[k]) if (mq[k].a == addr) h = 1'b1;
    return h;
  endfunction

  // One clock cycle: drive, compare at negedge, advance the model across the posedge.
  task automatic step(input bit rst, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [31:0] ap, input bit bv, input logic [4:0] ba,
                      input logic [31:0] bd, input logic [31:0] bp, input bit dr,
                      input logic [4:0] q1, input logic [4:0] q2);
    bit   exp_ar, exp_br;
    ent_t e;
    reset = rst; i_a_valid = av; i_a_addr = aa; i_a_data = ad; i_a_pc = ap;
    i_b_valid = bv; i_b_addr = ba; i_b_data = bd; i_b_pc = bp;
    i_drain_en = dr; i_q_addr1 = q1; i_q_addr2 = q2;
    @(negedge clk);
    exp_ar = (mq.size() < DEPTH);
    exp_br = exp_ar && !av;
    check("a_ready", 64'(o_a_ready), 64'(exp_ar));
    check("b_ready", 64'(o_b_ready), 64'(exp_br));
    check("count",   64'(o_count),   64'(mq.size()));
    check("grf_we",  64'(o_grf_we),  64'(m_we));
    check("grf_a3",  64'(o_grf_a3),  64'(m_a3));
    check("grf_wd",  64'(o_grf_wd),  64'(m_wd));
    check("grf_pc",  64'(o_grf_pc),  64'(m_pc));
    check("q_hit1",  64'(o_q_hit1),  64'(model_hit(q1)));
    check("q_hit2",  64'(o_q_hit2),  64'(model_hit(q2)));
    s_a_ready = o_a_ready; s_b_ready = o_b_ready; s_hit1 = o_q_hit1; s_hit2 = o_q_hit2;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
    end else begin
      if (dr && mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_a3 = e.a; m_wd = e.d; m_pc = e.p;
      end else begin
        m_we = 1'b0;
      end
      if (av && exp_ar) begin
        if (aa != 5'd0) mq.push_back('{a: aa, d: ad, p: ap});
      end else if (bv && exp_br) begin
        if (ba != 5'd0) mq.push_back('{a: ba, d: bd, p: bp});
      end
    end
    #1;
  endtask

  task automatic idle(input bit dr, input logic [4:0] q1, input logic [4:0] q2);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, dr, q1, q2);
  endtask

  task automatic wr_a(input logic [4:0] aa, input logic [31:0] ad, input logic [31:0] ap, input bit dr);
    step(1'b0, 1'b1, aa, ad, ap, 1'b0, 5'd0, 32'd0, 32'd0, dr, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; i_a_valid = 1'b0; i_b_valid = 1'b0; i_drain_en = 1'b0;
    i_a_addr = '0; i_a_data = '0; i_a_pc = '0; i_b_addr = '0; i_b_data = '0; i_b_pc = '0;
    i_q_addr1 = '0; i_q_addr2 = '0;
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with reset still held for one compared cycle.
    step(1'b1, 1'b1, 5'd7, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7, 5'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_we", 64'(o_grf_we), 64'd0);
    check("rst_a_ready", 64'(s_a_ready), 64'd1);
    check("rst_b_ready_avalid", 64'(s_b_ready), 64'd0);

    // Single write from A, drained one cycle after acceptance.
    wr_a(5'd5, 32'h1234_5678, 32'h3000, 1'b1);
    check("single_count_queued", 64'(o_count), 64'd1);
    check("single_we_not_yet", 64'(o_grf_we), 64'd0);
    idle(1'b1, 5'd0, 5'd0);
    check("single_we", 64'(o_grf_we), 64'd1);
    check("single_a3", 64'(o_grf_a3), 64'd5);
    check("single_wd", 64'(o_grf_wd), 64'h1234_5678);
    check("single_pc", 64'(o_grf_pc), 64'h3000);
    check("single_count_back", 64'(o_count), 64'd0);
    idle(1'b1, 5'd0, 5'd0);
    check("single_we_drop", 64'(o_grf_we), 64'd0);

    // A/B conflict: A wins, B retries and drains next.
    step(1'b0, 1'b1, 5'd3, 32'hA3, 32'h100, 1'b1, 5'd4, 32'hB4, 32'h200, 1'b1, 5'd0, 5'd0);
    check("conflict_b_ready", 64'(s_b_ready), 64'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd4, 32'hB4, 32'h200, 1'b1, 5'd0, 5'd0);
    check("conflict_b_ready_retry", 64'(s_b_ready), 64'd1);
    check("conflict_first_a3", 64'(o_grf_a3), 64'd3);
    idle(1'b1, 5'd0, 5'd0);
    check("conflict_second_we", 64'(o_grf_we), 64'd1);
    check("conflict_second_a3", 64'(o_grf_a3), 64'd4);
    idle(1'b1, 5'd0, 5'd0);

    // Fill, stall a fifth request, drain in order; then a second lap for pointer wrap.
    for (int lap = 0; lap < 2; lap++) begin
      for (int r = 1; r <= DEPTH; r++) wr_a(5'(r + 8 * lap), 32'(r * 17), 32'(r * 4), 1'b0);
      check("fill_count", 64'(o_count), 64'(DEPTH));
      check("fill_a_ready", 64'(o_a_ready), 64'd0);
      wr_a(5'd30, 32'hDEAD, 32'hBEEF, 1'b0);
      check("fill_stall_ready", 64'(s_a_ready), 64'd0);
      check("fill_stall_count", 64'(o_count), 64'(DEPTH));
      for (int r = 1; r <= DEPTH; r++) begin
        idle(1'b1, 5'd0, 5'd0);
        check("drain_a3", 64'(o_grf_a3), 64'(r + 8 * lap));
        check("drain_wd", 64'(o_grf_wd), 64'(r * 17));
      end
      idle(1'b1, 5'd0, 5'd0);
    end

    // Write to $0 is accepted but never reaches the GRF.
    wr_a(5'd0, 32'hFFFF_FFFF, 32'h44, 1'b1);
    check("zero_ready", 64'(s_a_ready), 64'd1);
    check("zero_count", 64'(o_count), 64'd0);
    idle(1'b1, 5'd0, 5'd0);
    check("zero_we", 64'(o_grf_we), 64'd0);
    check("zero_hit", 64'(s_hit1), 64'd0);

    // Hazard lookup through queue and output register.
    wr_a(5'd8, 32'h88, 32'h800, 1'b0);
    idle(1'b0, 5'd8, 5'd9);
    check("haz_hit_q", 64'(s_hit1), 64'd1);
    check("haz_miss", 64'(s_hit2), 64'd0);
    idle(1'b1, 5'd8, 5'd9);
    idle(1'b1, 5'd8, 5'd9);
    check("haz_hit_outreg", 64'(s_hit1), 64'd1);
    idle(1'b1, 5'd8, 5'd9);
    check("haz_hit_gone", 64'(s_hit1), 64'd0);

    // Reset with three entries queued.
    for (int r = 0; r < 3; r++) wr_a(5'(20 + r), 32'(r), 32'(r), 1'b0);
    check("pre_rst_count", 64'(o_count), 64'd3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    check("midrst_count", 64'(o_count), 64'd0);
    check("midrst_we", 64'(o_grf_we), 64'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 5'd21, 5'd20);
      check("post_rst_no_write", 64'(o_grf_we), 64'd0);
    end

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom, $urandom,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom, $urandom,
           ($urandom_range(0, 99) < 60),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/grf_write_queue.md
# grf_write_queue

Write-back buffer sitting in front of the GRF write port (WE/A3/WD/PC). It accepts register write requests from two producers:
- the pipeline W stage (source A, priority);
- a multi-cycle unit (source B).

It queues them in order and drains at most one per cycle into a registered GRF write port. It also exposes pending-write lookup for the hazard unit so reads of a register with a queued write stall instead of reading stale data.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- AW, $clog2(DEPTH), pointer width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  source A write request
- a_ready  out  1  source A accepted when a_valid & a_ready at posedge
- a_addr  in  5  destination register
- a_data  in  32  write data
- a_pc  in  32  PC of producing instruction
- b_valid, b_ready, b_addr, b_data, b_pc: same as source A, for source B
- drain_en  in  1  permits popping one entry this cycle
- grf_we  out  1  GRF write enable (registered)
- grf_a3  out  5  GRF write address (registered)
- grf_wd  out  32  GRF write data (registered)
- grf_pc  out  32  PC for GRF trace (registered)
- q_addr1, q_addr2  in  5  lookup addresses (rs, rt)
- q_hit1, q_hit2  out  1  pending write to lookup address exists (combinational)
- count  out  AW+1  queued entries, excluding the output register

## Operation
- Storage: circular FIFO of DEPTH entries {addr, data, pc}, with wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH) and count.
- At most one enqueue per cycle:
  - a_ready = (count < DEPTH).
  - b_ready = (count < DEPTH) & ~a_valid.
  - Source A always wins a same-cycle conflict; B retries.
- Write to $0: handshake completes normally (ready as above), but nothing is enqueued and count is unchanged.
- Pop: on posedge with drain_en=1 and count>0, the head entry loads the output register, grf_we<=1, rd_ptr++.
  - Otherwise grf_we<=0; grf_a3, grf_wd and grf_pc hold their last values.
- Push and pop on the same edge: both happen, and count is unchanged.
- Full: ready is deasserted even if a pop happens on the same edge. There is no same-cycle bypass of a freed slot.
- Empty with push: the new entry is not visible to a pop on that same edge; there is no FIFO bypass.
- Ordering: entries leave in acceptance order, whatever their source.
- Lookup: q_hitN=1 iff q_addrN≠0 and q_addrN matches either of:
  - any occupied FIFO slot's addr;
  - grf_a3 while grf_we=1.
  - A request being presented but not yet accepted does not count.
- Reset mid-operation: every queued entry and the output register are discarded. Producers must reissue.

## Timing
- Reset values:
  - grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, count=0, pointers=0.
  - a_ready=1; b_ready=~a_valid.
  - q_hit1=q_hit2=0.
- Latency, empty queue with drain_en held high:
  - request accepted at edge t;
  - popped at edge t+1;
  - grf_we=1 for the cycle t+1..t+2;
  - the GRF commits at edge t+2.
- Throughput: one write per cycle sustained when drain_en=1.
- count updates on the same edge as the push/pop that changes it. Ready signals derive from the registered count only, plus a_valid for B.
- q_hit is combinational from registered state and q_addr, so it is valid in the same cycle.

## Test plan
- Single write from A: addr=5, data=0x1234_5678, pc=0x3000, drain_en=1 -> grf_we=1, grf_a3=5, grf_wd=0x12345678, grf_pc=0x3000 exactly one cycle after acceptance; count returns to 0.
- Conflict: a_valid and b_valid both high, addr 3 and 4 -> b_ready=0 that cycle; A's addr 3 drains first and B's addr 4 drains next, on consecutive cycles.
- Fill with drain_en=0: DEPTH=4 writes to regs 1..4 -> count=4, a_ready=0. A 5th request stalls. Raise drain_en -> outputs drain in order 1,2,3,4, with wrap-around verified by a further 4 writes.
- $0 write: a_addr=0, data=0xFFFF_FFFF -> accepted, count stays 0, grf_we never asserts; q_addr1=0 -> q_hit1=0.
- Hazard lookup: queue holds reg 8 with drain_en=0 -> q_addr1=8 gives q_hit1=1 and q_addr2=9 gives q_hit2=0. After the drain cycle, hit stays 1 while grf_we=1, then drops to 0.
- Reset mid-operation: 3 entries queued, reset pulsed one cycle -> count=0 and grf_we=0 next cycle; no stale write appears after reset release.
